// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : run_ctrl
//  Purpose  : Button debouncer plus CPU run/program/halt mode controller.
//             Raw buttons are synchronized and debounced; rising-edge pulses
//             of the start/program/step channels drive a small mode FSM whose
//             state decodes into CPU clock enable, CPU reset and UART
//             programmer reset.
//  Options  : define RUN_CTRL_SINGLE_STEP_EN to build the HALT mode and the
//             single-step clock-enable pulse; without it STEP is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module run_ctrl #(
  parameter int              NBTN      = 5,
  parameter int              DEB_W     = 20,
  parameter logic [DEB_W-1:0] DEB_MAX  = 20'd500000,
  parameter int              BTN_START = 3,
  parameter int              BTN_PROG  = 2,
  parameter int              BTN_STEP  = 1
) (
  input  logic            clock,
  input  logic            rst_n,
  input  logic [NBTN-1:0] button,
  input  logic            upg_done_i,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_pulse,
  output logic            cpu_ce,
  output logic            cpu_rst_o,
  output logic            upg_rst_o,
  output logic [1:0]      state_o
);

  // Mode encoding doubles as the externally visible state code.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PROG = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
`ifdef RUN_CTRL_SINGLE_STEP_EN
  localparam logic [1:0] ST_HALT = 2'b11;
`endif

  // Counter value on which the debounced level flips.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_MAX - 1'b1;

  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;

  // Two-flop synchronizer for every raw button.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  generate
    for (genvar i = 0; i < NBTN; i++) begin : g_chan
      logic [DEB_W-1:0] cnt;
      logic             lvl;
      logic             pls;

      // Count consecutive cycles of disagreement; flip the level once the
      // synced input has differed for DEB_MAX cycles. Rising flips pulse.
      always_ff @(posedge clock) begin
        if (!rst_n) begin
          cnt <= '0;
          lvl <= 1'b0;
          pls <= 1'b0;
        end else begin
          pls <= 1'b0;
          if (sync2[i] == lvl) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            cnt <= '0;
            lvl <= ~lvl;
            pls <= ~lvl;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign btn_level[i] = lvl;
      assign btn_pulse[i] = pls;
    end
  endgenerate

  logic done_s1;
  logic done_s2;
  logic done_s3;
  logic armed;
  logic done_rise;

  // Cross the programmer done level into this domain and keep one history
  // flop for edge detection; 'armed' masks the first edge after reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      done_s1 <= 1'b0;
      done_s2 <= 1'b0;
      done_s3 <= 1'b0;
      armed   <= 1'b0;
    end else begin
      done_s1 <= upg_done_i;
      done_s2 <= done_s1;
      done_s3 <= done_s2;
      armed   <= 1'b1;
    end
  end

  assign done_rise = armed & done_s2 & ~done_s3;

  logic       prog_p;
  logic       start_p;
  logic [1:0] state;
  logic [1:0] state_next;

  assign prog_p  = btn_pulse[BTN_PROG];
  assign start_p = btn_pulse[BTN_START];

`ifdef RUN_CTRL_SINGLE_STEP_EN
  logic step_p;
  logic step_q;
  logic step_next;

  assign step_p = btn_pulse[BTN_STEP];
  // A lone STEP pulse while halted grants exactly one enabled CPU cycle.
  assign step_next = (state == ST_HALT) & step_p & ~prog_p & ~start_p;
`endif

  // State register (and the single-step flop when built).
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
`ifdef RUN_CTRL_SINGLE_STEP_EN
      step_q <= 1'b0;
`endif
    end else begin
      state  <= state_next;
`ifdef RUN_CTRL_SINGLE_STEP_EN
      step_q <= step_next;
`endif
    end
  end

  // Next-state selection; PROG outranks START, which outranks STEP.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (prog_p)       state_next = ST_PROG;
        else if (start_p) state_next = ST_RUN;
      end
      ST_PROG: begin
        if (prog_p || done_rise) state_next = ST_IDLE;
      end
      ST_RUN: begin
        if (prog_p)       state_next = ST_PROG;
`ifdef RUN_CTRL_SINGLE_STEP_EN
        else if (step_p)  state_next = ST_HALT;
`endif
      end
`ifdef RUN_CTRL_SINGLE_STEP_EN
      ST_HALT: begin
        if (prog_p)       state_next = ST_PROG;
        else if (start_p) state_next = ST_RUN;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    cpu_ce    = 1'b0;
    cpu_rst_o = 1'b1;
    upg_rst_o = 1'b1;
    case (state)
      ST_IDLE: begin
        cpu_ce    = 1'b0;
        cpu_rst_o = 1'b1;
        upg_rst_o = 1'b1;
      end
      ST_PROG: begin
        cpu_ce    = 1'b0;
        cpu_rst_o = 1'b1;
        upg_rst_o = 1'b0;
      end
      ST_RUN: begin
        cpu_ce    = 1'b1;
        cpu_rst_o = 1'b0;
        upg_rst_o = 1'b1;
      end
`ifdef RUN_CTRL_SINGLE_STEP_EN
      ST_HALT: begin
        cpu_ce    = step_q;
        cpu_rst_o = 1'b0;
        upg_rst_o = 1'b1;
      end
`endif
      default: begin
        cpu_ce    = 1'b0;
        cpu_rst_o = 1'b1;
        upg_rst_o = 1'b1;
      end
    endcase
  end

  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_ctrl
//  Purpose  : Directed self-checking bench for run_ctrl with DEB_MAX=4.
//             Expected mode outputs are queued when a stimulus step is
//             issued and popped for comparison once the DUT has reacted.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_run_ctrl;

  localparam int NBTN = 5;
  localparam logic [4:0] M_START = 5'b01000;
  localparam logic [4:0] M_PROG  = 5'b00100;
  localparam logic [4:0] M_STEP  = 5'b00010;

  logic            clock;
  logic            rst_n;
  logic [NBTN-1:0] button;
  logic            upg_done_i;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_pulse;
  logic            cpu_ce;
  logic            cpu_rst_o;
  logic            upg_rst_o;
  logic [1:0]      state_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  exp_t sb[$];

  run_ctrl #(
    .NBTN      (NBTN),
    .DEB_W     (20),
    .DEB_MAX   (20'd4),
    .BTN_START (3),
    .BTN_PROG  (2),
    .BTN_STEP  (1)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .button     (button),
    .upg_done_i (upg_done_i),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .cpu_ce     (cpu_ce),
    .cpu_rst_o  (cpu_rst_o),
    .upg_rst_o  (upg_rst_o),
    .state_o    (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(string tag, logic [1:0] st, logic ce, logic cr, logic ur);
    exp_t e;
    e.tag = tag;
    e.exp = {st, ce, cr, ur};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [4:0] obs;
    obs = {state_o, cpu_ce, cpu_rst_o, upg_rst_o};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%b expected=queued_entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed={st,ce,crst,urst}=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  // Hold buttons until the debounced pulse appears, then check the mode
  // reached on the following edge.
  task automatic press(string tag, logic [4:0] mask, logic [1:0] st,
                       logic ce, logic cr, logic ur);
    button = button | mask;
    repeat (6) tick();
    check({tag, "_pulse"}, 32'(btn_pulse & mask), 32'(mask));
    push_exp(tag, st, ce, cr, ur);
    tick();
    check_out();
  endtask

  task automatic release_btn(string tag, logic [4:0] mask);
    int pulses;
    pulses = 0;
    button = button & ~mask;
    repeat (7) begin
      tick();
      if (btn_pulse !== '0) pulses++;
    end
    check({tag, "_rel_nopulse"}, 32'(pulses), 32'd0);
    check({tag, "_rel_level"}, 32'(btn_level & mask), 32'd0);
  endtask

  initial begin
    int pulses;
    bit seen;
    rst_n      = 1'b0;
    button     = '0;
    upg_done_i = 1'b0;

    // Power-on reset.
    repeat (3) tick();
    push_exp("por", 2'b00, 1'b0, 1'b1, 1'b1);
    check_out();
    check("por_level", 32'(btn_level), 32'd0);
    check("por_pulse", 32'(btn_pulse), 32'd0);
    rst_n = 1'b1;
    tick();

    // Bouncing START button must never produce a pulse.
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      button[3] = ((c / 2) % 2 == 0);
      tick();
      if (btn_pulse !== '0) pulses++;
    end
    button[3] = 1'b0;
    repeat (4) begin
      tick();
      if (btn_pulse !== '0) pulses++;
    end
    check("bounce_nopulse", 32'(pulses), 32'd0);
    push_exp("bounce_idle", 2'b00, 1'b0, 1'b1, 1'b1);
    check_out();

    // Stable hold: level rises after exactly 6 cycles, one-cycle pulse,
    // then IDLE -> RUN on the next edge.
    button[3] = 1'b1;
    repeat (5) tick();
    check("hold_level_early", 32'(btn_level[3]), 32'd0);
    tick();
    check("hold_level_rise", 32'(btn_level[3]), 32'd1);
    check("hold_pulse", 32'(btn_pulse[3]), 32'd1);
    push_exp("start_run", 2'b10, 1'b1, 1'b0, 1'b1);
    tick();
    check_out();
    check("hold_pulse_once", 32'(btn_pulse[3]), 32'd0);
    release_btn("start", M_START);

    // RUN -> PROG, then done flag returns to IDLE.
    press("run_prog", M_PROG, 2'b01, 1'b0, 1'b1, 1'b0);
    release_btn("prog", M_PROG);
    push_exp("prog_hold", 2'b01, 1'b0, 1'b1, 1'b0);
    check_out();
    upg_done_i = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      tick();
      if (state_o === 2'b00) seen = 1'b1;
    end
    push_exp("prog_done_idle", 2'b00, 1'b0, 1'b1, 1'b1);
    check_out();
    upg_done_i = 1'b0;
    tick();

    press("idle_start", M_START, 2'b10, 1'b1, 1'b0, 1'b1);
    release_btn("start2", M_START);

`ifdef RUN_CTRL_SINGLE_STEP_EN
    press("run_halt", M_STEP, 2'b11, 1'b0, 1'b0, 1'b1);
    release_btn("step1", M_STEP);
    press("halt_step", M_STEP, 2'b11, 1'b1, 1'b0, 1'b1);
    push_exp("halt_step_end", 2'b11, 1'b0, 1'b0, 1'b1);
    tick();
    check_out();
    release_btn("step2", M_STEP);
    press("halt_run", M_START, 2'b10, 1'b1, 1'b0, 1'b1);
    release_btn("start3", M_START);
`else
    press("run_step_ignored", M_STEP, 2'b10, 1'b1, 1'b0, 1'b1);
    release_btn("step1", M_STEP);
`endif

    // Reset while running.
    rst_n = 1'b0;
    repeat (3) tick();
    push_exp("rst_in_run", 2'b00, 1'b0, 1'b1, 1'b1);
    check_out();
    check("rst_level", 32'(btn_level), 32'd0);
    rst_n = 1'b1;
    tick();
    push_exp("post_rst_idle", 2'b00, 1'b0, 1'b1, 1'b1);
    check_out();

    // Coincident PROG and START in IDLE: PROG wins; a second PROG aborts.
    press("prio_prog", M_PROG | M_START, 2'b01, 1'b0, 1'b1, 1'b0);
    release_btn("prio", M_PROG | M_START);
    press("prog_abort", M_PROG, 2'b00, 1'b0, 1'b1, 1'b1);
    release_btn("abort", M_PROG);

    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter NBTN, default 5, number of raw button channels.
REQ-002 SHALL have parameter DEB_W, default 20, debounce counter width.
REQ-003 SHALL have parameter DEB_MAX, default 20'd500000, stable cycles required before a debounced level changes; range 1..2^DEB_W-1.
REQ-004 SHALL have parameters BTN_START, BTN_PROG and BTN_STEP, defaults 3, 2 and 1: channel indices of the start, program and step buttons, all distinct and < NBTN.
REQ-005 SHALL have port clock, input, 1, single system clock; all flops rise on its posedge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port button, input, NBTN, raw asynchronous buttons, active high.
REQ-008 SHALL have port upg_done_i, input, 1, UART programmer done flag from another clock domain; level signal.
REQ-009 SHALL have port btn_level, output, NBTN, debounced button levels.
REQ-010 SHALL have port btn_pulse, output, NBTN, one-cycle pulse on each debounced 0->1 transition.
REQ-011 SHALL have port cpu_ce, output, 1, CPU clock enable.
REQ-012 SHALL have port cpu_rst_o, output, 1, CPU reset, active high.
REQ-013 SHALL have port upg_rst_o, output, 1, UART programmer reset, active high; 0 enables programming.
REQ-014 SHALL have port state_o, output, 2, current mode: IDLE=00, PROG=01, RUN=10, HALT=11.

Function
REQ-015 SHALL pass each button bit through a 2-flop synchronizer, then a per-channel counter: counter clears while the synced value equals btn_level; otherwise it increments, and btn_level toggles and the counter clears on the edge where the counter reaches DEB_MAX-1.
REQ-016 SHALL give a stable raw change a latency of exactly 2+DEB_MAX cycles to btn_level; any glitch shorter than DEB_MAX cycles SHALL leave btn_level unchanged.
REQ-017 SHALL register btn_pulse[i] high for exactly the one cycle in which btn_level[i] is first high; 1->0 transitions SHALL produce no pulse.
REQ-018 SHALL synchronize upg_done_i with 2 flops and detect its rising edge (done_rise) with one further flop.
REQ-019 SHALL implement transitions on the edge after the btn_pulse cycle, using pulse priority PROG > START > STEP when pulses coincide.
REQ-020 SHALL transition IDLE->PROG on PROG and IDLE->RUN on START; STEP SHALL be ignored in IDLE.
REQ-021 SHALL transition PROG->IDLE on done_rise or on a PROG pulse (abort); START and STEP SHALL be ignored in PROG.
REQ-022 SHALL transition RUN->PROG on PROG and RUN->HALT on STEP.
REQ-023 SHALL transition HALT->PROG on PROG and HALT->RUN on START; a STEP pulse in HALT SHALL drive cpu_ce high for exactly the next cycle and keep the state HALT.
REQ-024 SHALL decode outputs from the state register as follows: IDLE gives cpu_ce=0, cpu_rst_o=1, upg_rst_o=1; PROG gives 0, 1, 0; RUN gives 1, 0, 1; HALT gives the step pulse, 0, 1.
REQ-025 SHALL not issue a step pulse for a STEP pulse arriving in the same cycle as a PROG or START pulse.

Reset
REQ-026 SHALL, on a clock edge with rst_n=0, set state IDLE, all synchronizers, counters, btn_level and btn_pulse to 0, cpu_ce=0, cpu_rst_o=1, upg_rst_o=1, regardless of current mode.
REQ-027 SHALL ignore done_rise on the first edge after reset release.

Configuration
REQ-028 SHALL, when macro RUN_CTRL_SINGLE_STEP_EN is defined, implement HALT and single-step as specified.
REQ-029 SHALL, when RUN_CTRL_SINGLE_STEP_EN is undefined, treat STEP pulses as ignored in every state, make HALT unreachable, and remove the step-pulse logic; state_o SHALL never read 11.

Verification (DEB_MAX=4)
REQ-030 SHALL verify reset: hold rst_n=0 for 3 edges in RUN -> state_o=00, cpu_ce=0, cpu_rst_o=1, upg_rst_o=1, btn_level=0.
REQ-031 SHALL verify debounce: button[3] toggles every 2 cycles for 20 cycles -> no btn_pulse; then held high -> btn_level[3] rises 6 cycles after the hold begins, btn_pulse[3] high exactly 1 cycle.
REQ-032 SHALL verify start: START pulse in IDLE -> next edge state_o=10, cpu_ce=1, cpu_rst_o=0.
REQ-033 SHALL verify programming: PROG pulse in RUN -> state_o=01, upg_rst_o=0, cpu_rst_o=1; upg_done_i rises -> state_o=00 within 4 edges, upg_rst_o=1.
REQ-034 SHALL verify single-step with the macro defined: STEP in RUN -> HALT, cpu_ce=0; second STEP -> cpu_ce=1 for exactly 1 cycle. With the macro undefined, STEP in RUN leaves state_o=10.
REQ-035 SHALL verify priority: PROG and START pulses coincide in IDLE -> state_o=01.
